// File: rtl/tactile_pkg.sv
// ============================================================
// tactile_pkg : shared scan state encoding and frame address layout
// Rev 1.0
// ============================================================
`default_nettype none

package tactile_pkg;

   localparam int ADC_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CONVERT = 3'd2,
      ST_WRITE   = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_HANDOFF = 3'd5,
      ST_HOLD    = 3'd6
   } scan_state_e;

   // Never returns 0, so a single-wire axis still gets a legal 1-bit vector
   function automatic int sel_width(input int cnt);
      return (cnt > 1) ? $clog2(cnt) : 1;
   endfunction

   function automatic int addr_width(input int sw_cnt, input int rd_cnt);
      return sel_width(sw_cnt * rd_cnt);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================
// sat_counter : increment-by-one counter that sticks at all-ones
// Rev 1.0
// ============================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/scan_sequencer.sv
// ============================================================
// scan_sequencer : walks the sensor matrix, converts each crossing and
//                  fills a ping-pong frame BRAM for convolution
// Rev 1.0
// ============================================================
`default_nettype none

module scan_sequencer
   import tactile_pkg::*;
#(
   parameter int SW_WIRE_CNT = 16,
   parameter int RD_WIRE_CNT = 16,
   parameter int SETTLE_SW   = 64,
   parameter int SETTLE_RD   = 8,
   parameter int ADC_TIMEOUT = 255
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           run,
   output logic [sel_width(SW_WIRE_CNT)-1:0]              sw_sel,
   output logic [sel_width(RD_WIRE_CNT)-1:0]              rd_sel,
   output logic                                           adc_start,
   input  logic                                           adc_valid,
   input  logic [ADC_W-1:0]                               adc_data,
   output logic                                           bram_we,
   output logic                                           bram_bank,
   output logic [addr_width(SW_WIRE_CNT, RD_WIRE_CNT)-1:0] bram_addr,
   output logic [ADC_W-1:0]                               bram_din,
   output logic                                           conv_start,
   output logic                                           conv_bank,
   input  logic                                           conv_busy,
   output logic [15:0]                                    frame_cnt,
   output logic [7:0]                                     overrun_cnt,
   output logic [7:0]                                     timeout_cnt
);

   localparam int SW_W    = sel_width(SW_WIRE_CNT);
   localparam int RD_W    = sel_width(RD_WIRE_CNT);
   localparam int ADDR_W  = addr_width(SW_WIRE_CNT, RD_WIRE_CNT);
   localparam int SET_MAX = (SETTLE_SW > SETTLE_RD) ? SETTLE_SW : SETTLE_RD;
   localparam int SET_W   = $clog2(SET_MAX + 1);
   localparam int TO_W    = $clog2(ADC_TIMEOUT + 1);

   localparam logic [SW_W-1:0]  SW_LAST = SW_W'(SW_WIRE_CNT - 1);
   localparam logic [RD_W-1:0]  RD_LAST = RD_W'(RD_WIRE_CNT - 1);
   localparam logic [SET_W-1:0] SET_SW  = SET_W'(SETTLE_SW);
   localparam logic [SET_W-1:0] SET_RD  = SET_W'(SETTLE_RD);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ADC_TIMEOUT);

   scan_state_e      state_q, state_d;
   logic [SW_W-1:0]  sw_sel_q, sw_sel_d;
   logic [RD_W-1:0]  rd_sel_q, rd_sel_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [TO_W-1:0]  timer_q, timer_d;
   logic             adc_start_q, adc_start_d;
   logic             bram_we_q, bram_we_d;
   logic [ADC_W-1:0] din_q, din_d;
   logic             bank_q, bank_d;
   logic             conv_start_q, conv_start_d;
   logic             conv_bank_q, conv_bank_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             last_cross;
   logic             handoff;
   logic             overrun_inc;
   logic             timeout_inc;

   always_comb begin
      state_d      = state_q;
      sw_sel_d     = sw_sel_q;
      rd_sel_d     = rd_sel_q;
      settle_d     = settle_q;
      timer_d      = timer_q;
      adc_start_d  = 1'b0;
      bram_we_d    = 1'b0;
      din_d        = din_q;
      bank_d       = bank_q;
      conv_start_d = 1'b0;
      conv_bank_d  = conv_bank_q;
      frame_cnt_d  = frame_cnt_q;
      overrun_inc  = 1'b0;
      timeout_inc  = 1'b0;
      last_cross   = (sw_sel_q == SW_LAST) && (rd_sel_q == RD_LAST);
      // The handoff decision is taken in the final WRITE (or in HOLD) so that
      // conv_start lands in the very next cycle, which is the HANDOFF state.
      handoff      = (((state_q == ST_WRITE) && last_cross) || (state_q == ST_HOLD)) && !conv_busy;

      case (state_q)
         ST_IDLE: begin
            sw_sel_d = '0;
            rd_sel_d = '0;
            if (run) begin
               settle_d = SET_SW;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q <= SET_W'(1)) begin
               settle_d    = '0;
               timer_d     = '0;
               adc_start_d = 1'b1;
               state_d     = ST_CONVERT;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         ST_CONVERT: begin
            // A strobe coincident with our own start request is stale
            if (adc_valid && !adc_start_q) begin
               din_d     = adc_data;
               bram_we_d = 1'b1;
               state_d   = ST_WRITE;
            end else if (timer_q == TO_LAST) begin
               din_d       = '0;
               timeout_inc = 1'b1;
               bram_we_d   = 1'b1;
               state_d     = ST_WRITE;
            end else begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         ST_WRITE: begin
            if (!last_cross) begin
               state_d = ST_ADVANCE;
            end else if (conv_busy) begin
               overrun_inc = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_ADVANCE: begin
            if (rd_sel_q != RD_LAST) begin
               rd_sel_d = rd_sel_q + RD_W'(1);
               settle_d = SET_RD;
            end else begin
               rd_sel_d = '0;
               sw_sel_d = sw_sel_q + SW_W'(1);
               settle_d = SET_SW;
            end
            state_d = ST_SETTLE;
         end
         ST_HANDOFF: begin
            if (run) begin
               settle_d = SET_SW;
               state_d  = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            state_d = ST_HOLD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (handoff) begin
         conv_start_d = 1'b1;
         conv_bank_d  = bank_q;
         bank_d       = ~bank_q;
         frame_cnt_d  = frame_cnt_q + 16'd1;
         sw_sel_d     = '0;
         rd_sel_d     = '0;
         state_d      = ST_HANDOFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sw_sel_q     <= '0;
         rd_sel_q     <= '0;
         settle_q     <= '0;
         timer_q      <= '0;
         adc_start_q  <= 1'b0;
         bram_we_q    <= 1'b0;
         din_q        <= '0;
         bank_q       <= 1'b0;
         conv_start_q <= 1'b0;
         conv_bank_q  <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         sw_sel_q     <= sw_sel_d;
         rd_sel_q     <= rd_sel_d;
         settle_q     <= settle_d;
         timer_q      <= timer_d;
         adc_start_q  <= adc_start_d;
         bram_we_q    <= bram_we_d;
         din_q        <= din_d;
         bank_q       <= bank_d;
         conv_start_q <= conv_start_d;
         conv_bank_q  <= conv_bank_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   sat_counter #(.WIDTH(8)) u_overrun_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (overrun_inc),
      .count (overrun_cnt)
   );

   sat_counter #(.WIDTH(8)) u_timeout_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (timeout_inc),
      .count (timeout_cnt)
   );

   assign sw_sel     = sw_sel_q;
   assign rd_sel     = rd_sel_q;
   assign adc_start  = adc_start_q;
   assign bram_we    = bram_we_q;
   assign bram_bank  = bank_q;
   assign bram_addr  = ADDR_W'(sw_sel_q) + ADDR_W'(rd_sel_q) * ADDR_W'(SW_WIRE_CNT);
   assign bram_din   = din_q;
   assign conv_start = conv_start_q;
   assign conv_bank  = conv_bank_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire
